// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the wide-write / narrow-read register file.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents:
//   BYTE_W        bits per byte-enable
//   lane_bits()   number of lane-select address bits for a given width ratio
package register_file_pkg;

    localparam int BYTE_W = 8;

    // RATIO=1 has no lane field at all, so this returns 0 rather than
    // relying on $clog2(1) inside a port-width expression.
    function automatic int lane_bits(input int ratio);
        return (ratio <= 1) ? 0 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/register_file_lane.sv
// One RDATA_WIDTH-wide column of the register file: byte-enable write, registered read.
// Latency: read data valid one clk after re_i; write visible to reads sampled on a later edge.
// Backpressure: none; accepts one read and one write every cycle.
//
// Ports:
//   clk, rst_n   clock and async active-low reset (read register only)
//   we_i         write strobe; waddr_i row, wbe_i byte enables, wdata_i data
//   re_i         read strobe; raddr_i row
//   rdata_o      registered read data (old contents on same-row collision)
module register_file_lane
    import register_file_pkg::*;
#(
    parameter int WADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we_i,
    input  logic [WADDR_WIDTH-1:0]          waddr_i,
    input  logic [RDATA_WIDTH/BYTE_W-1:0]   wbe_i,
    input  logic [RDATA_WIDTH-1:0]          wdata_i,
    input  logic                            re_i,
    input  logic [WADDR_WIDTH-1:0]          raddr_i,
    output logic [RDATA_WIDTH-1:0]          rdata_o
);

    localparam int NB = RDATA_WIDTH / BYTE_W;

    // Storage is deliberately not reset so the array maps onto block RAM.
    logic [RDATA_WIDTH-1:0] mem_q [2**WADDR_WIDTH];
    logic [RDATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
                end
            end
        end
    end

    // Read-first: a same-row write on this edge is not seen here; the top
    // level merges the new bytes back in when write-first is wanted.
    // Only updates on re_i so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/register_file_1w_wide_1r_narrow.sv
// Register file, one RATIO*RDATA_WIDTH write port with byte enables, one RDATA_WIDTH read port.
// Latency: ReadValid/ReadData one cycle after the read request (two with OUT_REG=1).
// Backpressure: none; fully pipelined, one read and one write accepted every cycle.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ReadEnable, ReadAddr             read request; ReadAddr = {row, lane}
//   ReadData, ReadValid              read result and its one-cycle qualifier
//   WriteEnable, WriteAddr           write request to a full row
//   WriteBE, WriteData               byte enables and wide write data
module register_file_1w_wide_1r_narrow
    import register_file_pkg::*;
#(
    parameter int WADDR_WIDTH = 5,
    parameter int RDATA_WIDTH = 32,
    parameter int RATIO       = 2,
    parameter int WDATA_WIDTH = RATIO * RDATA_WIDTH,
    parameter int RADDR_WIDTH = WADDR_WIDTH + lane_bits(RATIO),
    parameter bit BYPASS      = 1'b1,
    parameter bit OUT_REG     = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ReadEnable,
    input  logic [RADDR_WIDTH-1:0]      ReadAddr,
    output logic [RDATA_WIDTH-1:0]      ReadData,
    output logic                        ReadValid,
    input  logic                        WriteEnable,
    input  logic [WADDR_WIDTH-1:0]      WriteAddr,
    input  logic [WDATA_WIDTH/8-1:0]    WriteBE,
    input  logic [WDATA_WIDTH-1:0]      WriteData
);

    localparam int NB  = RDATA_WIDTH / BYTE_W;
    localparam int LB  = lane_bits(RATIO);
    // Lane select is kept at least one bit wide; with RATIO=1 the array
    // below gets a padding slot so the index width always matches.
    localparam int LSW        = (LB > 0) ? LB : 1;
    localparam int LANE_SLOTS = 2**LSW;

    logic [WADDR_WIDTH-1:0] rd_row;
    logic [LSW-1:0]         rd_lane;

    assign rd_row = ReadAddr[RADDR_WIDTH-1 -: WADDR_WIDTH];

    generate
        if (LB > 0) begin : g_lane_addr
            assign rd_lane = ReadAddr[LB-1:0];
        end else begin : g_no_lane_addr
            assign rd_lane = '0;
        end
    endgenerate

    logic [NB-1:0]          lane_wbe   [LANE_SLOTS];
    logic [RDATA_WIDTH-1:0] lane_wdat  [LANE_SLOTS];
    logic [RDATA_WIDTH-1:0] lane_rdata [LANE_SLOTS];

    generate
        for (genvar k = 0; k < LANE_SLOTS; k++) begin : g_lane
            if (k < RATIO) begin : g_col
                assign lane_wbe[k]  = WriteBE[k*NB +: NB];
                assign lane_wdat[k] = WriteData[k*RDATA_WIDTH +: RDATA_WIDTH];

                register_file_lane #(
                    .WADDR_WIDTH (WADDR_WIDTH),
                    .RDATA_WIDTH (RDATA_WIDTH)
                ) u_lane (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .we_i    (WriteEnable),
                    .waddr_i (WriteAddr),
                    .wbe_i   (lane_wbe[k]),
                    .wdata_i (lane_wdat[k]),
                    .re_i    (ReadEnable),
                    .raddr_i (rd_row),
                    .rdata_o (lane_rdata[k])
                );
            end else begin : g_pad
                assign lane_wbe[k]   = '0;
                assign lane_wdat[k]  = '0;
                assign lane_rdata[k] = '0;
            end
        end
    endgenerate

    // Write-first bypass: the columns always return old contents, so on a
    // same-row collision we capture the colliding write bytes of the selected
    // lane and overlay them on the column output one cycle later.
    logic collide;
    assign collide = BYPASS && WriteEnable && (WriteAddr == rd_row);

    logic [LSW-1:0]         lane_sel_q, lane_sel_d;
    logic [NB-1:0]          byp_be_q,   byp_be_d;
    logic [RDATA_WIDTH-1:0] byp_dat_q,  byp_dat_d;
    logic                   vld1_q;

    always_comb begin
        lane_sel_d = lane_sel_q;
        byp_be_d   = byp_be_q;
        byp_dat_d  = byp_dat_q;
        // Everything read-side only moves on a request, so ReadData holds
        // steady through idle cycles.
        if (ReadEnable) begin
            lane_sel_d = rd_lane;
            byp_be_d   = collide ? lane_wbe[rd_lane] : '0;
            byp_dat_d  = lane_wdat[rd_lane];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_sel_q <= '0;
            byp_be_q   <= '0;
            byp_dat_q  <= '0;
            vld1_q     <= 1'b0;
        end else begin
            lane_sel_q <= lane_sel_d;
            byp_be_q   <= byp_be_d;
            byp_dat_q  <= byp_dat_d;
            vld1_q     <= ReadEnable;
        end
    end

    // Mux on the registered lane, never on the live ReadAddr.
    logic [RDATA_WIDTH-1:0] rd_merged;

    always_comb begin
        rd_merged = lane_rdata[lane_sel_q];
        for (int b = 0; b < NB; b++) begin
            if (byp_be_q[b]) begin
                rd_merged[BYTE_W*b +: BYTE_W] = byp_dat_q[BYTE_W*b +: BYTE_W];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [RDATA_WIDTH-1:0] rdata_q;
            logic                   vld2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    vld2_q  <= 1'b0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) begin
                        rdata_q <= rd_merged;
                    end
                end
            end

            assign ReadData  = rdata_q;
            assign ReadValid = vld2_q;
        end else begin : g_no_out_reg
            assign ReadData  = rd_merged;
            assign ReadValid = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_1w_wide_1r_narrow.sv
module tb_register_file_1w_wide_1r_narrow;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: RATIO=2 BYPASS=1 OUT_REG=0   dut1: RATIO=2 BYPASS=0 OUT_REG=1 (share inputs)
    // dut2: RATIO=4 BYPASS=1 OUT_REG=0   dut3: RATIO=1 BYPASS=1 OUT_REG=1
    logic        re_ab, we_ab;
    logic [5:0]  raddr_ab;
    logic [4:0]  waddr_ab;
    logic [7:0]  be_ab;
    logic [63:0] wd_ab;

    logic         re_c, we_c;
    logic [6:0]   raddr_c;
    logic [4:0]   waddr_c;
    logic [15:0]  be_c;
    logic [127:0] wd_c;

    logic        re_d, we_d;
    logic [4:0]  raddr_d, waddr_d;
    logic [3:0]  be_d;
    logic [31:0] wd_d;

    logic [3:0]       rv;
    logic [3:0][31:0] rd;

    register_file_1w_wide_1r_narrow #(.RATIO(2), .BYPASS(1'b1), .OUT_REG(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .ReadEnable(re_ab), .ReadAddr(raddr_ab), .ReadData(rd[0]), .ReadValid(rv[0]),
        .WriteEnable(we_ab), .WriteAddr(waddr_ab), .WriteBE(be_ab), .WriteData(wd_ab));

    register_file_1w_wide_1r_narrow #(.RATIO(2), .BYPASS(1'b0), .OUT_REG(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .ReadEnable(re_ab), .ReadAddr(raddr_ab), .ReadData(rd[1]), .ReadValid(rv[1]),
        .WriteEnable(we_ab), .WriteAddr(waddr_ab), .WriteBE(be_ab), .WriteData(wd_ab));

    register_file_1w_wide_1r_narrow #(.RATIO(4), .BYPASS(1'b1), .OUT_REG(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .ReadEnable(re_c), .ReadAddr(raddr_c), .ReadData(rd[2]), .ReadValid(rv[2]),
        .WriteEnable(we_c), .WriteAddr(waddr_c), .WriteBE(be_c), .WriteData(wd_c));

    register_file_1w_wide_1r_narrow #(.RATIO(1), .BYPASS(1'b1), .OUT_REG(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n),
        .ReadEnable(re_d), .ReadAddr(raddr_d), .ReadData(rd[3]), .ReadValid(rv[3]),
        .WriteEnable(we_d), .WriteAddr(waddr_d), .WriteBE(be_d), .WriteData(wd_d));

    typedef struct {
        logic [31:0] dat;
        int          due;
    } sb_t;

    sb_t sb_q [4][$];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [7:0]  be;
        logic [63:0] wd;
        logic        re;
        logic [5:0]  raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vt [12];

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected read result becomes due 'lat' cycles after the edge that samples it.
    task automatic push(input int d, input logic [31:0] dat, input int lat);
        sb_t e;
        e.dat = dat;
        e.due = cyc + lat;
        sb_q[d].push_back(e);
    endtask

    task automatic monitor();
        sb_t e;
        if (!rst_n) return;
        for (int d = 0; d < 4; d++) begin
            if (rv[d]) begin
                n_vec++;
                if (sb_q[d].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid dut%0d: got data %h at cycle %0d, expected no ReadValid", d, rd[d], cyc);
                end else begin
                    e = sb_q[d].pop_front();
                    if (rd[d] !== e.dat || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL read dut%0d: got %h at cycle %0d, expected %h at cycle %0d", d, rd[d], cyc, e.dat, e.due);
                    end
                end
            end else if (sb_q[d].size() > 0 && sb_q[d][0].due <= cyc) begin
                n_vec++;
                n_bad++;
                e = sb_q[d].pop_front();
                $display("FAIL missing_valid dut%0d: got no ReadValid at cycle %0d, expected %h", d, cyc, e.dat);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    initial begin
        logic [31:0] exp_c [4];

        rst_n = 1'b0;
        re_ab = 1'b0; we_ab = 1'b0; raddr_ab = '0; waddr_ab = '0; be_ab = '0; wd_ab = '0;
        re_c  = 1'b0; we_c  = 1'b0; raddr_c  = '0; waddr_c  = '0; be_c  = '0; wd_c  = '0;
        re_d  = 1'b0; we_d  = 1'b0; raddr_d  = '0; waddr_d  = '0; be_d  = '0; wd_d  = '0;

        //             we    waddr  be     wdata                   re    raddr  exp dut0      exp dut1
        vt[0]  = '{1'b1, 5'd3, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0, 6'd0,  32'h0,        32'h0};
        vt[1]  = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd6,  32'h0123_4567, 32'h0123_4567};
        vt[2]  = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[3]  = '{1'b1, 5'd3, 8'h0F, 64'h0,                   1'b0, 6'd0,  32'h0,        32'h0};
        vt[4]  = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[5]  = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd6,  32'h0,        32'h0};
        vt[6]  = '{1'b1, 5'd5, 8'hFF, 64'h1111_1111_1111_1111, 1'b0, 6'd0,  32'h0,        32'h0};
        vt[7]  = '{1'b1, 5'd5, 8'h30, 64'h2222_2222_2222_2222, 1'b1, 6'd11, 32'h1111_2222, 32'h1111_1111};
        vt[8]  = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd11, 32'h1111_2222, 32'h1111_2222};
        vt[9]  = '{1'b1, 5'd5, 8'h00, 64'h3333_3333_3333_3333, 1'b1, 6'd10, 32'h1111_1111, 32'h1111_1111};
        vt[10] = '{1'b1, 5'd6, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 6'd10, 32'h1111_1111, 32'h1111_1111};
        vt[11] = '{1'b0, 5'd0, 8'h00, 64'h0,                   1'b1, 6'd12, 32'hAAAA_AAAA, 32'hAAAA_AAAA};

        // Reset state
        #2;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_valid_dut%0d", d), 32'(rv[d]), 32'h0);
            chk($sformatf("reset_data_dut%0d", d), rd[d], 32'h0);
        end
        repeat (2) tick();
        rst_n = 1'b1;

        // Table: full/partial writes, collisions, independent rows
        for (int i = 0; i < 12; i++) begin
            tick();
            we_ab = vt[i].we; waddr_ab = vt[i].waddr; be_ab = vt[i].be; wd_ab = vt[i].wd;
            re_ab = vt[i].re; raddr_ab = vt[i].raddr;
            if (vt[i].re) begin
                push(0, vt[i].exp_a, 1);
                push(1, vt[i].exp_b, 2);
            end
        end
        tick();
        we_ab = 1'b0; re_ab = 1'b0;
        repeat (4) tick();

        // Idle: data holds, no valid
        chk("hold_data_dut0", rd[0], 32'hAAAA_AAAA);
        chk("hold_valid_dut0", 32'(rv[0]), 32'h0);
        chk("hold_data_dut1", rd[1], 32'hAAAA_AAAA);
        chk("hold_valid_dut1", 32'(rv[1]), 32'h0);

        // Fill all rows, then 64 back-to-back reads
        for (int r = 0; r < 32; r++) begin
            tick();
            we_ab = 1'b1; waddr_ab = 5'(r); be_ab = 8'hFF; wd_ab = {pat(2*r+1), pat(2*r)};
        end
        for (int a = 0; a < 64; a++) begin
            tick();
            we_ab = 1'b0;
            re_ab = 1'b1; raddr_ab = 6'(a);
            push(0, pat(a), 1);
            push(1, pat(a), 2);
        end
        tick();
        re_ab = 1'b0;
        repeat (3) tick();

        // Reset with reads in flight
        tick();
        re_ab = 1'b1; raddr_ab = 6'd20;
        push(0, pat(20), 1);
        tick();
        raddr_ab = 6'd21;
        @(posedge clk);
        #1;
        chk("inflight_valid_dut1", 32'(rv[1]), 32'h1);
        chk("inflight_data_dut1", rd[1], pat(20));
        rst_n = 1'b0;
        re_ab = 1'b0;
        #1;
        chk("midreset_valid_dut0", 32'(rv[0]), 32'h0);
        chk("midreset_data_dut0", rd[0], 32'h0);
        chk("midreset_valid_dut1", 32'(rv[1]), 32'h0);
        chk("midreset_data_dut1", rd[1], 32'h0);
        for (int d = 0; d < 4; d++) sb_q[d].delete();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postreset_valid_dut0", 32'(rv[0]), 32'h0);
            chk("postreset_valid_dut1", 32'(rv[1]), 32'h0);
        end
        tick();
        re_ab = 1'b1; raddr_ab = 6'd20;
        push(0, pat(20), 1); push(1, pat(20), 2);
        tick();
        raddr_ab = 6'd21;
        push(0, pat(21), 1); push(1, pat(21), 2);
        tick();
        re_ab = 1'b0;
        repeat (3) tick();

        // RATIO=4: lanes zero-extended 16-bit values, plus a single-lane partial write
        exp_c[0] = 32'h0000_1111; exp_c[1] = 32'h0000_2222;
        exp_c[2] = 32'h0000_3333; exp_c[3] = 32'h0000_4444;
        tick();
        we_c = 1'b1; waddr_c = 5'd0; be_c = 16'hFFFF;
        wd_c = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
        tick();
        waddr_c = 5'd1; be_c = 16'h00F0; wd_c = {4{32'h5555_5555}};
        for (int a = 0; a < 4; a++) begin
            tick();
            we_c = 1'b0;
            re_c = 1'b1; raddr_c = 7'(a);
            push(2, exp_c[a], 1);
        end
        tick();
        raddr_c = 7'd5;
        push(2, 32'h5555_5555, 1);
        tick();
        re_c = 1'b0;

        // RATIO=1 smoke with a collision on the same row
        tick();
        we_d = 1'b1; waddr_d = 5'd2; be_d = 4'hF; wd_d = 32'hCAFE_F00D;
        tick();
        be_d = 4'h1; wd_d = 32'h0000_00AA;
        re_d = 1'b1; raddr_d = 5'd2;
        push(3, 32'hCAFE_F0AA, 2);
        tick();
        we_d = 1'b0;
        push(3, 32'hCAFE_F0AA, 2);
        tick();
        re_d = 1'b0;

        repeat (6) tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("drain_dut%0d", d), 32'(sb_q[d].size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
